fifo_rd_stream: RTL and testbench

//  Drain stage on the read side of the async FIFO (rd_clk domain). Issues fifo_rd_en,

---
 rtl/fifo_rd_stream.sv | 106 ++++++++++
 tb/tb_fifo_rd_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: credit-based reads into a 3-entry capture
// buffer, presented as a packet-framed valid/ready stream. Optional stats: FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_r_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] beat_cnt
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]          word_count,
  output logic [15:0]          stall_count
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_FULL  = 2'd3
  } occ_e;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  occ_e             occ, occ_nxt;
  logic             inflight;
  logic [1:0]       wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [3];
  logic             push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is only issued when a buffer slot is guaranteed for its data, counting
  // the word already in flight; this is what removes any m_ready -> fifo_rd_en path.
  assign fifo_rd_en = rst_n & ~fifo_empty & (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  assign push   = inflight;
  assign pop    = m_valid & m_ready;
  assign m_data = mem[rd_ptr];
  assign m_last = m_valid & (beat_cnt == LAST_BEAT);

  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      case (occ)
        OCC_EMPTY: occ_nxt = OCC_ONE;
        OCC_ONE:   occ_nxt = OCC_TWO;
        default:   occ_nxt = OCC_FULL;
      endcase
    end else if (pop && !push) begin
      case (occ)
        OCC_FULL: occ_nxt = OCC_TWO;
        OCC_TWO:  occ_nxt = OCC_ONE;
        default:  occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= OCC_EMPTY;
      m_valid  <= 1'b0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      for (int unsigned i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      occ      <= occ_nxt;
      m_valid  <= (occ_nxt != OCC_EMPTY);
      inflight <= fifo_rd_en;
      if (push) begin
        mem[wr_ptr] <= fifo_r_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop && word_count != '1) word_count <= word_count + 16'd1;
      if (m_valid && !m_ready && stall_count != '1) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, expected
// beats are queued at write time and popped by a monitor on every accepted beat.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_r_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] beat_cnt;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] word_count, stall_count;
`endif

  fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_r_data(fifo_r_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .beat_cnt(beat_cnt)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .word_count(word_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [3:0] beat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[$];
  logic [7:0] wr_words[$];
  int wr_taken = 0, flush_gen = 0, flush_done = 0, bad_rd = 0;
  int errors = 0, checks = 0, acc_cnt = 0, word_obs = 0, stall_obs = 0, k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a FIFO write; framing of each word follows from its position since reset.
  task automatic put(input logic [7:0] d);
    exp_q.push_back('{d: d, last: (k % 4 == 3), beat: 4'(k % 4)});
    wr_words.push_back(d);
    k++;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (acc_cnt < target) begin
      errors++;
      $display("FAIL %s: timeout, beats got %0d expected %0d", name, acc_cnt, target);
    end
  endtask

  initial begin
    int pulses, viol, base, n;
    fork
      forever begin : fifo_model
        @(posedge clk);
        if (flush_gen != flush_done) begin
          fq.delete();
          wr_taken   = wr_words.size();
          flush_done = flush_gen;
        end
        if (fifo_rd_en) begin
          if (fq.size() == 0) bad_rd++;
          else fifo_r_data <= fq.pop_front();
        end
        while (wr_taken < wr_words.size()) begin
          fq.push_back(wr_words[wr_taken]);
          wr_taken++;
        end
        fifo_empty <= (fq.size() == 0);
      end
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (rst_n && m_valid) begin
          if (m_ready) begin
            acc_cnt++;
            word_obs++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat: unexpected beat data=%0h", m_data);
            end else begin
              e = exp_q.pop_front();
              chk("beat{data,last,beat_cnt}", 32'({m_data, m_last, beat_cnt}), 32'(e));
            end
          end else begin
            stall_obs++;
          end
        end
      end
    join_none

    // Reset with a non-empty FIFO, then release
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) put(8'(i));
    repeat (3) tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_beat", 32'(beat_cnt), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    rst_n = 1'b1;
    #1;
    chk("release_rd_en", 32'(fifo_rd_en), 1);

    // Fill latency and full-rate burst
    tick();
    chk("lat_cycle1_valid", 32'(m_valid), 0);
    tick();
    chk("lat_cycle2_valid", 32'(m_valid), 1);
    repeat (8) tick();
    chk("burst_beats", 32'(acc_cnt), 8);
    chk("burst_drained", 32'(m_valid), 0);

    // Backpressure with a full FIFO
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) put(8'(i));
    pulses = 0;
    repeat (12) begin
      tick();
      if (fifo_rd_en) pulses++;
    end
    chk("bp_rd_pulses", 32'(pulses), 3);
    chk("bp_hold_valid", 32'(m_valid), 1);
    chk("bp_hold_data", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    wait_acc(16, 40, "bp_drain");

    // Empty FIFO idle, then a single word
    viol = 0;
    repeat (20) begin
      tick();
      if (fifo_rd_en || m_valid) viol++;
    end
    chk("empty_idle", 32'(viol), 0);
    put(8'hA5);
    wait_acc(17, 10, "single_word");
    repeat (4) tick();
    chk("single_count", 32'(acc_cnt), 17);
    chk("single_drained", 32'(m_valid), 0);

    // Random m_ready and random fill
    n = 0;
    while (n < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        put(8'($urandom));
        n++;
      end
      tick();
    end
    m_ready = 1'b1;
    wait_acc(217, 600, "random_drain");
    chk("random_sb_empty", 32'(exp_q.size()), 0);

    // Align to a packet boundary, then reset after two beats of a packet
    base = acc_cnt;
    while (k % 4 != 0) put(8'hE0 + 8'(k % 4));
    wait_acc(base + 3, 20, "align_drain");
    base = acc_cnt;
    for (int i = 0; i < 6; i++) put(8'h61 + 8'(i));
    n = 0;
    while (acc_cnt < base + 2 && n < 20) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("mid_beats", 32'(acc_cnt), 32'(base + 2));
    chk("mid_beat_cnt", 32'(beat_cnt), 2);
    chk("mid_valid", 32'(m_valid), 1);
    chk("mid_data", 32'(m_data), 32'h63);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stats_word_count", 32'(word_count), 32'(word_obs));
    chk("stats_stall_count", 32'(stall_count), 32'(stall_obs));
`endif
    rst_n = 1'b0;
    flush_gen++;
    exp_q.delete();
    k = 0;
    word_obs = 0;
    stall_obs = 0;
    #1;
    chk("midrst_valid", 32'(m_valid), 0);
    chk("midrst_beat", 32'(beat_cnt), 0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 0);
    chk("midrst_last", 32'(m_last), 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("midrst_word_count", 32'(word_count), 0);
    chk("midrst_stall_count", 32'(stall_count), 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    base = acc_cnt;
    put(8'h77);
    wait_acc(base + 1, 10, "post_rst_word");
    repeat (4) tick();
    chk("post_rst_count", 32'(acc_cnt), 32'(base + 1));
    chk("post_rst_drained", 32'(m_valid), 0);
    chk("no_underflow", 32'(bad_rd), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
